// File: rtl/cache_mem_arbiter_if.sv
// Bundles the two cache request ports, the shared memory port and the per-cache
// return/hold signals; master is the arbiter side, slave the caches plus memory.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              icache_req;
  logic [ADDR_W-1:0] icache_addr;
  logic              dcache_req;
  logic              dcache_wr;
  logic [ADDR_W-1:0] dcache_addr;
  logic [ADDR_W-1:0] dcache_wdata;
  logic              mem_data_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_enable;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_wdata;
  logic              icache_data_valid;
  logic              dcache_data_valid;
  logic              icache_wait;
  logic              dcache_wait;
  logic              dcache_wr_done;

  modport master (
    input  icache_req, icache_addr, dcache_req, dcache_wr, dcache_addr,
           dcache_wdata, mem_data_valid,
    output mem_addr, mem_enable, mem_wr, mem_wdata, icache_data_valid,
           dcache_data_valid, icache_wait, dcache_wait, dcache_wr_done
  );

  modport slave (
    output icache_req, icache_addr, dcache_req, dcache_wr, dcache_addr,
           dcache_wdata, mem_data_valid,
    input  mem_addr, mem_enable, mem_wr, mem_wdata, icache_data_valid,
           dcache_data_valid, icache_wait, dcache_wait, dcache_wr_done
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shared memory-port arbiter for I-cache fills, D-cache fills and D-cache stores; grant 1 cycle after request, outputs combinational.
// Losers are held via *_wait; stores win over fills; ARB_ROUND_ROBIN_EN selects round-robin fill tie-break (else I-cache wins).
module cache_mem_arbiter #(
  parameter int FILL_WORDS = 8,
  parameter int ADDR_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  cache_mem_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(FILL_WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FILL_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFILL  = 2'd1,
    DFILL  = 2'd2,
    DWRITE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_i_q, last_i_d;

  logic [ADDR_W-1:0] mem_addr_c;
  logic              mem_enable_c;
  logic              mem_wr_c;
  logic [ADDR_W-1:0] mem_wdata_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_i_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_i_q <= last_i_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_i_d = last_i_q;
    case (state_q)
      IDLE: begin
        if (bus.dcache_wr) begin
          state_d = DWRITE;
        end else if (bus.icache_req && bus.dcache_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_d = last_i_q ? DFILL : IFILL;
`else
          state_d = IFILL;
`endif
        end else if (bus.icache_req) begin
          state_d = IFILL;
        end else if (bus.dcache_req) begin
          state_d = DFILL;
        end
      end
      IFILL, DFILL: begin
        // Grant is held until the whole block returns, regardless of the request line.
        if (bus.mem_data_valid) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d    = '0;
            state_d  = IDLE;
            last_i_d = (state_q == IFILL);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DWRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr_c   = '0;
    mem_enable_c = 1'b0;
    mem_wr_c     = 1'b0;
    mem_wdata_c  = '0;
    case (state_q)
      IFILL: begin
        mem_addr_c   = bus.icache_addr;
        mem_enable_c = bus.icache_req;
      end
      DFILL: begin
        mem_addr_c   = bus.dcache_addr;
        mem_enable_c = bus.dcache_req;
      end
      DWRITE: begin
        mem_addr_c   = bus.dcache_addr;
        mem_enable_c = 1'b1;
        mem_wr_c     = 1'b1;
        mem_wdata_c  = bus.dcache_wdata;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr          = mem_addr_c;
  assign bus.mem_enable        = mem_enable_c;
  assign bus.mem_wr            = mem_wr_c;
  assign bus.mem_wdata         = mem_wdata_c;
  assign bus.icache_data_valid = bus.mem_data_valid & (state_q == IFILL);
  assign bus.dcache_data_valid = bus.mem_data_valid & (state_q == DFILL);
  assign bus.icache_wait       = (state_q != IFILL);
  assign bus.dcache_wait       = (state_q != DFILL) & ~(state_q == DWRITE);
  assign bus.dcache_wr_done    = (state_q == DWRITE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: per-cycle vector table plus hand sequences
// for the fill tie-break and asynchronous reset in the middle of a fill.
module tb_cache_mem_arbiter;

  logic clk;
  logic rst_n;

  cache_mem_arbiter_if #(.ADDR_W(16)) bus ();

  cache_mem_arbiter #(.FILL_WORDS(8), .ADDR_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic [15:0] iaddr;
    logic        dreq;
    logic        dwr;
    logic [15:0] daddr;
    logic [15:0] dwdata;
    logic        mdv;
    logic [38:0] exp;
  } vec_t;

  vec_t vq[$];
  int   n_tests;
  int   n_failed;

  function automatic vec_t mk(input logic ireq, input logic [15:0] iaddr,
                              input logic dreq, input logic dwr,
                              input logic [15:0] daddr, input logic [15:0] dwdata,
                              input logic mdv,
                              input logic [15:0] e_addr, input logic e_en,
                              input logic e_wr, input logic [15:0] e_wdata,
                              input logic e_idv, input logic e_ddv,
                              input logic e_iw, input logic e_dw,
                              input logic e_done);
    vec_t v;
    v.ireq   = ireq;
    v.iaddr  = iaddr;
    v.dreq   = dreq;
    v.dwr    = dwr;
    v.daddr  = daddr;
    v.dwdata = dwdata;
    v.mdv    = mdv;
    v.exp    = {e_addr, e_en, e_wr, e_wdata, e_idv, e_ddv, e_iw, e_dw, e_done};
    return v;
  endfunction

  function automatic logic [38:0] outs();
    return {bus.mem_addr, bus.mem_enable, bus.mem_wr, bus.mem_wdata,
            bus.icache_data_valid, bus.dcache_data_valid,
            bus.icache_wait, bus.dcache_wait, bus.dcache_wr_done};
  endfunction

  task automatic chk(input string name, input logic [38:0] act, input logic [38:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ireq, input logic [15:0] iaddr, input logic dreq,
                       input logic dwr, input logic [15:0] daddr,
                       input logic [15:0] dwdata, input logic mdv);
    bus.icache_req     = ireq;
    bus.icache_addr    = iaddr;
    bus.dcache_req     = dreq;
    bus.dcache_wr      = dwr;
    bus.dcache_addr    = daddr;
    bus.dcache_wdata   = dwdata;
    bus.mem_data_valid = mdv;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  localparam logic [38:0] RST_OUT = {16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    n_tests  = 0;
    n_failed = 0;
    rst_n    = 1'b0;
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 0);

    // I fill of 8 words with a gap, address tracking
    vq.push_back(mk(1, 16'h0040, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 1, 1, 0));
    vq.push_back(mk(1, 16'h0040, 0, 0, 16'h0, 16'h0, 1, 16'h0040, 1, 0, 16'h0, 1, 0, 0, 1, 0));
    vq.push_back(mk(1, 16'h0041, 0, 0, 16'h0, 16'h0, 1, 16'h0041, 1, 0, 16'h0, 1, 0, 0, 1, 0));
    vq.push_back(mk(1, 16'h0042, 0, 0, 16'h0, 16'h0, 0, 16'h0042, 1, 0, 16'h0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 6; i++)
      vq.push_back(mk(1, 16'h0043 + 16'(i), 0, 0, 16'h0, 16'h0, 1,
                      16'h0043 + 16'(i), 1, 0, 16'h0, 1, 0, 0, 1, 0));
    vq.push_back(mk(0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 1, 1, 0));
    // Store beats a pending I fill, then IDLE, then IFILL
    vq.push_back(mk(1, 16'h0050, 0, 1, 16'h1234, 16'hBEEF, 0, 16'h0, 0, 0, 16'h0, 0, 0, 1, 1, 0));
    vq.push_back(mk(1, 16'h0050, 0, 0, 16'h1234, 16'hBEEF, 0, 16'h1234, 1, 1, 16'hBEEF, 0, 0, 1, 0, 1));
    vq.push_back(mk(1, 16'h0050, 0, 0, 16'h1234, 16'hBEEF, 0, 16'h0, 0, 0, 16'h0, 0, 0, 1, 1, 0));
    // I fill with request dropped after 3 words
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(1, 16'h0100 + 16'(i), 0, 0, 16'h0, 16'h0, 1,
                      16'h0100 + 16'(i), 1, 0, 16'h0, 1, 0, 0, 1, 0));
    vq.push_back(mk(0, 16'h0103, 0, 0, 16'h0, 16'h0, 1, 16'h0103, 0, 0, 16'h0, 1, 0, 0, 1, 0));
    vq.push_back(mk(0, 16'h0103, 0, 0, 16'h0, 16'h0, 0, 16'h0103, 0, 0, 16'h0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(0, 16'h0104 + 16'(i), 0, 0, 16'h0, 16'h0, 1,
                      16'h0104 + 16'(i), 0, 0, 16'h0, 1, 0, 0, 1, 0));
    // Stray valids in IDLE, then a D fill needing all 8 words
    vq.push_back(mk(0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 16'h0, 0, 0, 16'h0, 0, 0, 1, 1, 0));
    vq.push_back(mk(0, 16'h0, 1, 0, 16'h2000, 16'h0, 1, 16'h0, 0, 0, 16'h0, 0, 0, 1, 1, 0));
    for (int i = 0; i < 7; i++)
      vq.push_back(mk(0, 16'h0, 1, 0, 16'h2000, 16'h0, 1, 16'h2000, 1, 0, 16'h0, 0, 1, 1, 0, 0));
    vq.push_back(mk(0, 16'h0, 1, 0, 16'h2000, 16'h0, 0, 16'h2000, 1, 0, 16'h0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 16'h0, 1, 0, 16'h2000, 16'h0, 1, 16'h2000, 1, 0, 16'h0, 0, 1, 1, 0, 0));
    vq.push_back(mk(0, 16'h0, 0, 0, 16'h2000, 16'h0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 1, 1, 0));

    @(negedge clk);
    #1 chk("reset_outputs", outs(), RST_OUT);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].ireq, vq[i].iaddr, vq[i].dreq, vq[i].dwr,
            vq[i].daddr, vq[i].dwdata, vq[i].mdv);
      #1 chk($sformatf("vec%0d", i), outs(), vq[i].exp);
      tick();
    end

    // Simultaneous fill requests held over two grants
    do_reset();
    drive(1, 16'h0040, 1, 0, 16'h3000, 16'h0, 0);
    tick();
    #1 chk("tie_grant1_is_I", {37'h0, bus.icache_wait, bus.dcache_wait}, {37'h0, 1'b0, 1'b1});
    bus.mem_data_valid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    bus.mem_data_valid = 1'b0;
    #1 chk("tie_idle_between", {37'h0, bus.icache_wait, bus.dcache_wait}, {37'h0, 1'b1, 1'b1});
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    #1 chk("tie_grant2_is_D", {37'h0, bus.icache_wait, bus.dcache_wait}, {37'h0, 1'b1, 1'b0});
`else
    #1 chk("tie_grant2_is_I", {37'h0, bus.icache_wait, bus.dcache_wait}, {37'h0, 1'b0, 1'b1});
`endif

    // Asynchronous reset after 5 words of an I fill, then a fresh 8-word fill
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    do_reset();
    drive(1, 16'h0040, 0, 0, 16'h0, 16'h0, 0);
    tick();
    bus.mem_data_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #1 chk("midfill_still_ifill", {37'h0, bus.icache_wait, bus.icache_data_valid},
           {37'h0, 1'b0, 1'b1});
    rst_n = 1'b0;
    #1 chk("async_reset_outputs", outs(), RST_OUT);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_data_valid = 1'b0;
    tick();
    #1 chk("restart_ifill", {37'h0, bus.icache_wait, bus.mem_enable}, {37'h0, 1'b0, 1'b1});
    bus.mem_data_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    #1 chk("restart_after7_still_ifill", {37'h0, bus.icache_wait}, {37'h0, 1'b0});
    tick();
    bus.mem_data_valid = 1'b0;
    bus.icache_req     = 1'b0;
    #1 chk("restart_after8_idle", outs(), RST_OUT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 50000", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the single shared main-memory port between the I-cache fill FSM and the D-cache (fill reads plus write-through stores). It sits directly downstream of both caches: it grants exclusive memory ownership to one requester at a time, routes the owner's address and data to memory, and steers memory's data-valid pulses back to the owning cache. Each cache's fill FSM is held off through its wait input.

## Interface
- FILL_WORDS, 8: words returned per cache-block fill; sizes the return counter.
- ADDR_W, 16: address and data width.

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- icache_req  in  1  I-cache fill FSM busy (miss being serviced)
- icache_addr  in  ADDR_W  I-cache sequential fill address
- dcache_req  in  1  D-cache fill request
- dcache_wr  in  1  D-cache write-through store request (single word)
- dcache_addr  in  ADDR_W  D-cache fill/store address
- dcache_wdata  in  ADDR_W  D-cache store data
- mem_data_valid  in  1  memory read data valid (one pulse per word)
- mem_addr  out  ADDR_W  address to memory
- mem_enable  out  1  memory access enable
- mem_wr  out  1  memory write strobe
- mem_wdata  out  ADDR_W  write data to memory
- icache_data_valid  out  1  mem_data_valid routed to I-cache
- dcache_data_valid  out  1  mem_data_valid routed to D-cache
- icache_wait  out  1  I-cache must hold; drives the I-cache fill FSM's arbitration hold input
- dcache_wait  out  1  D-cache must hold
- dcache_wr_done  out  1  one-cycle pulse, store accepted

## Operation
- States: IDLE, IFILL, DFILL, DWRITE. The state register is 2 bits. The return counter is clog2(FILL_WORDS)+1 bits. The last-served flag `last_i` is 1 when the I-cache was served last.
- IDLE:
  - dcache_wr has the highest priority and goes to DWRITE.
  - Otherwise, if only icache_req is set, go to IFILL. If only dcache_req is set, go to DFILL.
  - If both are set, the tie-break is decided by the configuration (see Configuration).
- IFILL:
  - mem_addr=icache_addr, mem_enable=icache_req, mem_wr=0.
  - Count mem_data_valid pulses. On the FILL_WORDS-th pulse, clear the counter, set last_i=1 and go to IDLE.
- DFILL: same as IFILL using the dcache_* signals. On exit, set last_i=0.
- DWRITE:
  - Lasts exactly one cycle: mem_enable=1, mem_wr=1, mem_addr=dcache_addr, mem_wdata=dcache_wdata, dcache_wr_done=1.
  - Then return to IDLE. last_i is unchanged.
- Grant is held until all FILL_WORDS words have returned, even if the requester deasserts its request early. The counter is not cleared on request drop.
- Data-valid routing:
  - icache_data_valid = mem_data_valid & (state==IFILL).
  - dcache_data_valid = mem_data_valid & (state==DFILL).
  - A mem_data_valid pulse in IDLE or DWRITE is dropped and does not advance the counter.
- Wait outputs:
  - icache_wait = (state!=IFILL).
  - dcache_wait = (state!=DFILL) & ~(state==DWRITE).
- In IDLE, all memory outputs are driven to 0.
- Reset (asynchronous, at any point including mid-fill): state=IDLE, counter=0, last_i=0.
  - Outputs after reset: mem_addr=0, mem_enable=0, mem_wr=0, mem_wdata=0, both data_valids=0, icache_wait=1, dcache_wait=1, dcache_wr_done=0.

## Timing
- Requests are sampled in IDLE at edge k. The grant state is entered at edge k+1, and mem_enable is asserted combinationally from the state during cycle k+1.
- Minimum request-to-memory latency is 1 cycle. IDLE lasts at least one cycle between consecutive grants.
- All outputs are combinational from the state register plus current inputs. Outputs have no register stage.
- The FILL_WORDS-th valid pulse at edge m means the state is IDLE during cycle m+1. A pending request is granted at edge m+2.
- A store occupies 2 cycles in total: the DWRITE cycle plus the following IDLE cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a simultaneous icache_req and dcache_req in IDLE, grant goes to the requester not served last. last_i=0 means the I-cache wins.
- ARB_ROUND_ROBIN_EN undefined: fixed priority. On a tie the I-cache always wins, and last_i is not used for arbitration.
- dcache_wr priority over fills is identical in both builds.

## Test plan
- Reset with icache_req=1 → next edge state=IFILL, mem_addr tracks icache_addr=0x0040. After 8 mem_data_valid pulses, icache_data_valid has pulsed 8 times, then icache_wait=1 and state=IDLE.
- icache_req=dcache_req=1 held through two fills, ARB_ROUND_ROBIN_EN defined → grant order is I, D. Undefined → grant order is I, I.
- dcache_wr=1, dcache_addr=0x1234, dcache_wdata=0xBEEF in IDLE with icache_req=1 → next cycle mem_wr=1, mem_addr=0x1234, mem_wdata=0xBEEF, dcache_wr_done=1. IFILL is entered two cycles later.
- Stray mem_data_valid in IDLE, then a D fill → the stray pulse is not routed, and the fill still needs 8 pulses to complete.
- rst_n low after the 5th valid of an I fill → all outputs go to their reset values immediately. After release with icache_req=1, the fill restarts and requires 8 fresh pulses.
- icache_req dropped after 3 valids → state stays IFILL until 5 more pulses arrive, with mem_enable=0 meanwhile.
